// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined Hack-style ALU with valid/ready handshakes.
// S1 registers the pre-processed operands; S2 registers the result and its flags.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cr,
  output logic             ov
);

  // Zero then optionally invert an operand.
  function automatic logic [WIDTH-1:0] pre_op(input logic [WIDTH-1:0] v,
                                               input logic z, input logic n);
    logic [WIDTH-1:0] t;
    t = z ? {WIDTH{1'b0}} : v;
    return n ? ~t : t;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] xa_q, xa_d, ya_q, ya_d;
  logic             f_q, f_d, no_q, no_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d, ng_q, ng_d, cr_q, cr_d, ov_q, ov_d;
  logic             s1_adv_s, s2_adv_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] r_s, res_s;

  // Advance conditions: a stage moves when it is empty or its successor moves.
  always_comb begin
    s2_adv_s = !s2_valid_q || out_ready;
    s1_adv_s = !s1_valid_q || s2_adv_s;
    in_ready = s1_adv_s && !reset;
  end

  // S1 next state: capture pre-processed operands or hold.
  always_comb begin
    s1_valid_d = s1_valid_q;
    xa_d       = xa_q;
    ya_d       = ya_q;
    f_d        = f_q;
    no_d       = no_q;
    if (s1_adv_s) begin
      s1_valid_d = in_valid;
      xa_d       = pre_op(x, zx, nx);
      ya_d       = pre_op(y, zy, ny);
      f_d        = f;
      no_d       = no;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // S2 next state: compute result and flags; carry/overflow come before the final inversion.
  always_comb begin
    sum_s      = {1'b0, xa_q} + {1'b0, ya_q};
    r_s        = f_q ? sum_s[WIDTH-1:0] : (xa_q & ya_q);
    res_s      = no_q ? ~r_s : r_s;
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    zr_d       = zr_q;
    ng_d       = ng_q;
    cr_d       = cr_q;
    ov_d       = ov_q;
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      out_d      = res_s;
      zr_d       = (res_s == {WIDTH{1'b0}});
      ng_d       = res_s[WIDTH-1];
      cr_d       = f_q & sum_s[WIDTH];
      ov_d       = f_q & (xa_q[WIDTH-1] == ya_q[WIDTH-1]) & (sum_s[WIDTH-1] != xa_q[WIDTH-1]);
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers with synchronous reset discarding any in-flight bundle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      xa_q       <= {WIDTH{1'b0}};
      ya_q       <= {WIDTH{1'b0}};
      f_q        <= 1'b0;
      no_q       <= 1'b0;
      s2_valid_q <= 1'b0;
      out_q      <= {WIDTH{1'b0}};
      zr_q       <= 1'b0;
      ng_q       <= 1'b0;
      cr_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      xa_q       <= xa_d;
      ya_q       <= ya_d;
      f_q        <= f_d;
      no_q       <= no_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      zr_q       <= zr_d;
      ng_q       <= ng_d;
      cr_q       <= cr_d;
      ov_q       <= ov_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign cr        = cr_q;
  assign ov        = ov_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus randomized traffic
// checked against an arithmetic reference model and a FIFO scoreboard.
module tb_alu_pipe;
  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready, zx, nx, zy, ny, f, no;
  logic [15:0] x, y;
  logic        in_ready, out_valid, zr, ng, cr, ov;
  logic [15:0] out;
  logic        in_ready8, out_valid8, zr8, ng8, cr8, ov8;
  logic [7:0]  out8;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zr(zr), .ng(ng), .cr(cr), .ov(ov));

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .x(x[7:0]), .y(y[7:0]),
    .out_valid(out_valid8), .out_ready(out_ready), .out(out8),
    .zr(zr8), .ng(ng8), .cr(cr8), .ov(ov8));

  // Reference: {out[15:0], zr, ng, cr, ov} from plain integer arithmetic.
  function automatic logic [19:0] model(input logic [5:0] c, input logic [15:0] xv,
                                        input logic [15:0] yv, input int w);
    longint m, half, xa, ya, s, r, sx, sy, ss;
    logic cr_e, ov_e, ng_e, zr_e;
    logic [15:0] r16;
    m = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    xa = c[5] ? 0 : (longint'(xv) & m);
    if (c[4]) xa = ~xa & m;
    ya = c[3] ? 0 : (longint'(yv) & m);
    if (c[2]) ya = ~ya & m;
    cr_e = 1'b0;
    ov_e = 1'b0;
    if (c[1]) begin
      s = xa + ya;
      r = s & m;
      cr_e = (s > m);
      sx = (xa >= half) ? xa - (m + 1) : xa;
      sy = (ya >= half) ? ya - (m + 1) : ya;
      ss = sx + sy;
      ov_e = (ss >= half) || (ss < -half);
    end else begin
      r = xa & ya;
    end
    if (c[0]) r = ~r & m;
    zr_e = (r == 0);
    ng_e = ((r >> (w - 1)) & 1) != 0;
    r16 = 16'(r);
    return {r16, zr_e, ng_e, cr_e, ov_e};
  endfunction

  task automatic set_ctrl(input logic [5:0] c);
    {zx, nx, zy, ny, f, no} = c;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one bundle with out_ready=1 and waits (bounded) for its result.
  task automatic run_op(input logic [5:0] c, input logic [15:0] xv, input logic [15:0] yv,
                        output logic acc, output int lat,
                        output logic [15:0] o16, output logic [3:0] f16,
                        output logic [7:0] o8, output logic [3:0] f8);
    set_ctrl(c);
    x = xv;
    y = yv;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    acc = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 9) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    o16 = out;
    f16 = {zr, ng, cr, ov};
    o8 = out8;
    f8 = {zr8, ng8, cr8, ov8};
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    set_ctrl(6'b000010);
    x = 16'h1234;
    y = 16'h0001;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if ({out, zr, ng, cr, ov} !== 20'h00000) begin bad++; $display("FAIL reset_outputs: got %h want 00000", {out, zr, ng, cr, ov}); end
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    logic acc; int lat; logic [15:0] o; logic [3:0] fl; logic [7:0] o8; logic [3:0] f8;
    run_op(6'b000010, 16'd5, 16'd3, acc, lat, o, fl, o8, f8);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL add_accept: got %b want 1", acc); end
    total++; if (lat != 1) begin bad++; $display("FAIL add_latency: got %0d want 1", lat); end
    total++; if (o !== 16'd8) begin bad++; $display("FAIL add_out: got %h want 0008", o); end
    total++; if (fl !== 4'b0000) begin bad++; $display("FAIL add_flags: got %b want 0000", fl); end
    idle(2);
  endtask

  task automatic test_controls;
    logic acc; int lat; logic [15:0] o; logic [3:0] fl; logic [7:0] o8; logic [3:0] f8;
    run_op(6'b010011, 16'd5, 16'd3, acc, lat, o, fl, o8, f8);
    total++; if (o !== 16'd2) begin bad++; $display("FAIL sub_out: got %h want 0002", o); end
    total++; if (fl !== 4'b0000) begin bad++; $display("FAIL sub_flags: got %b want 0000", fl); end
    run_op(6'b111010, 16'h1234, 16'h5678, acc, lat, o, fl, o8, f8);
    total++; if (o !== 16'hFFFF) begin bad++; $display("FAIL neg1_out: got %h want ffff", o); end
    total++; if (fl !== 4'b0100) begin bad++; $display("FAIL neg1_flags: got %b want 0100", fl); end
    idle(2);
  endtask

  task automatic test_flags;
    logic acc; int lat; logic [15:0] o; logic [3:0] fl; logic [7:0] o8; logic [3:0] f8;
    run_op(6'b000010, 16'h7FFF, 16'h0001, acc, lat, o, fl, o8, f8);
    total++; if (o !== 16'h8000) begin bad++; $display("FAIL ovf_out: got %h want 8000", o); end
    total++; if (fl !== 4'b0101) begin bad++; $display("FAIL ovf_flags: got %b want 0101", fl); end
    run_op(6'b000010, 16'hFFFF, 16'h0001, acc, lat, o, fl, o8, f8);
    total++; if (o !== 16'h0000) begin bad++; $display("FAIL wrap_out: got %h want 0000", o); end
    total++; if (fl !== 4'b1010) begin bad++; $display("FAIL wrap_flags: got %b want 1010", fl); end
    run_op(6'b000011, 16'h7FFF, 16'h0001, acc, lat, o, fl, o8, f8);
    total++; if ({o, fl} !== {16'h7FFF, 4'b0001}) begin bad++; $display("FAIL no_keeps_ov: got %h/%b want 7fff/0001", o, fl); end
    idle(2);
  endtask

  task automatic test_width8;
    logic acc; int lat; logic [15:0] o; logic [3:0] fl; logic [7:0] o8; logic [3:0] f8;
    run_op(6'b000010, 16'h0080, 16'h0080, acc, lat, o, fl, o8, f8);
    total++; if ({o8, f8} !== {8'h00, 4'b1011}) begin bad++; $display("FAIL w8_add: got %h/%b want 00/1011", o8, f8); end
    run_op(6'b000001, 16'h00F0, 16'h003C, acc, lat, o, fl, o8, f8);
    total++; if ({o8, f8} !== {8'hCF, 4'b0100}) begin bad++; $display("FAIL w8_and_not: got %h/%b want cf/0100", o8, f8); end
    idle(2);
  endtask

  task automatic test_backpressure;
    logic held_ok;
    set_ctrl(6'b000010);
    y = 16'h0000;
    out_ready = 1'b0;
    in_valid = 1'b1;
    x = 16'd1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1: got %b want 1", in_ready); end
    @(posedge clk); #1;
    x = 16'd2;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready2: got %b want 1", in_ready); end
    @(posedge clk); #1;
    x = 16'd3;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full: got %b want 0", in_ready); end
    held_ok = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (!(out_valid === 1'b1 && out === 16'd1 && in_ready === 1'b0)) held_ok = 1'b0;
    end
    total++; if (held_ok !== 1'b1) begin bad++; $display("FAIL bp_hold: got out=%h valid=%b want out=0001 valid=1", out, out_valid); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if ({out_valid, out} !== {1'b1, 16'd2}) begin bad++; $display("FAIL bp_second: got %b/%h want 1/0002", out_valid, out); end
    @(posedge clk); #1;
    total++; if ({out_valid, out} !== {1'b1, 16'd3}) begin bad++; $display("FAIL bp_third: got %b/%h want 1/0003", out_valid, out); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midflight;
    logic seen;
    set_ctrl(6'b000010);
    y = 16'h0000;
    out_ready = 1'b0;
    in_valid = 1'b1;
    x = 16'h0011;
    @(posedge clk); #1;
    x = 16'h0022;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_loaded: got %b want 1", out_valid); end
    reset = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    total++; if ({out_valid, out, zr, ng, cr, ov} !== 21'h0) begin bad++; $display("FAIL mid_reset_out: got %h want 0", {out_valid, out, zr, ng, cr, ov}); end
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_after_ready: got %b want 1", in_ready); end
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_ghost: got %b want 0", seen); end
  endtask

  task automatic test_random;
    logic [19:0] q16[$];
    logic [19:0] q8[$];
    logic [19:0] e16, e8, held_val;
    logic [5:0]  c;
    logic        held, exp_ready, in_fire;
    int          n;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    held = 1'b0;
    held_val = 20'h0;
    for (int i = 0; i < 460; i++) begin
      if (i < 400) begin
        c = 6'($urandom);
        set_ctrl(c);
        x = 16'($urandom);
        y = 16'($urandom);
        in_valid = ($urandom_range(3) != 0);
        out_ready = ($urandom_range(2) != 0);
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      exp_ready = !(q16.size() == 2 && !out_ready);
      total++; if (in_ready !== exp_ready) begin bad++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, in_ready, exp_ready); end
      if (out_valid && held) begin
        total++; if ({out, zr, ng, cr, ov} !== held_val) begin bad++; $display("FAIL rnd_stable[%0d]: got %h want %h", i, {out, zr, ng, cr, ov}, held_val); end
      end
      if (out_valid && out_ready) begin
        if (q16.size() == 0) begin
          total++; bad++; $display("FAIL rnd_spurious[%0d]: got out=%h want none", i, out);
        end else begin
          e16 = q16.pop_front();
          e8 = q8.pop_front();
          total++; if ({out, zr, ng, cr, ov} !== e16) begin bad++; $display("FAIL rnd_w16[%0d]: got %h want %h", i, {out, zr, ng, cr, ov}, e16); end
          total++; if ({8'h00, out8, zr8, ng8, cr8, ov8} !== e8) begin bad++; $display("FAIL rnd_w8[%0d]: got %h want %h", i, {8'h00, out8, zr8, ng8, cr8, ov8}, e8); end
        end
      end
      held = out_valid && !out_ready;
      held_val = {out, zr, ng, cr, ov};
      in_fire = in_valid && in_ready;
      if (in_fire) begin
        q16.push_back(model({zx, nx, zy, ny, f, no}, x, y, 16));
        q8.push_back(model({zx, nx, zy, ny, f, no}, x, y, 8));
      end
      @(posedge clk); #1;
    end
    n = q16.size();
    total++; if (n != 0) begin bad++; $display("FAIL rnd_drain: got %0d left want 0", n); end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_ctrl(6'b000000);
    x = 16'h0000;
    y = 16'h0000;
    @(posedge clk); #1;
    test_reset;
    test_basic;
    test_controls;
    test_flags;
    test_width8;
    test_backpressure;
    test_reset_midflight;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit combinational Hack-style ALU.
- Keeps the six-bit control semantics (zx, nx, zy, ny, f, no).
- Adds a generic WIDTH, a two-stage registered pipeline with valid/ready handshakes on both sides, and two adder flags (carry, signed overflow) alongside zr/ng.
- Sits between the CPU decode/operand-fetch logic and writeback; accepts one operation per cycle under full throughput.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/control bundle presented.
- in_ready  output  1  block can accept the bundle this cycle.
- zx  input  1  zero x.
- nx  input  1  invert x (after zx).
- zy  input  1  zero y.
- ny  input  1  invert y (after zy).
- f  input  1  1 = x+y, 0 = x&y.
- no  input  1  invert result.
- x  input  WIDTH  operand x.
- y  input  WIDTH  operand y.
- out_valid  output  1  result bundle valid.
- out_ready  input  1  consumer takes the result this cycle.
- out  output  WIDTH  result.
- zr  output  1  out == 0.
- ng  output  1  out[WIDTH-1].
- cr  output  1  adder carry-out; 0 when f=0.
- ov  output  1  adder signed overflow; 0 when f=0.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Transfers: input transfer occurs on a rising edge where in_valid && in_ready. Output transfer occurs on a rising edge where out_valid && out_ready.
- Stage 1 (S1) registers:
  - xa = nx ? ~(zx ? 0 : x) : (zx ? 0 : x)
  - ya, formed the same way from zy, ny, y
  - f, no
  - s1_valid
- Stage 2 (S2) registers:
  - r = f ? xa+ya (mod 2^WIDTH) : xa&ya
  - out = no ? ~r : r
  - zr = (out == 0)
  - ng = out[WIDTH-1]
  - cr = f & carry-out of xa+ya
  - ov = f & (xa[MSB] == ya[MSB]) & (sum[MSB] != xa[MSB])
  - cr and ov are taken before the `no` inversion. They are unaffected by `no`.
  - s2_valid drives out_valid.
- Advance rules (combinational):
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv && !reset
- Pipeline moves:
  - S2 loads from S1 when s2_adv; s2_valid <= s1_valid.
  - S1 loads the input when s1_adv; s1_valid <= in_valid.
  - A stage that does not advance holds all its registers.
- Latency: a bundle accepted at edge N is presented with out_valid=1 after edge N+1, provided there is no backpressure. Throughput is 1/cycle.
- Order: strictly FIFO. No bundle is dropped or duplicated. At most 2 bundles are in flight.
- Stability: while out_valid && !out_ready, out/zr/ng/cr/ov are held bit-stable.
- Full condition: both stages valid and out_ready=0 → in_ready=0.
- Simultaneous input transfer and output transfer in the same cycle is legal. Occupancy is unchanged.
- Empty condition: out_valid=0. Output data registers hold their last value and are don't-care to consumers.
- Reset (any cycle, including mid-operation):
  - Next edge: s1_valid = s2_valid = 0.
  - out, zr, ng, cr, ov = 0.
  - All S1 data registers = 0.
  - In-flight bundles are discarded.
  - in_ready = 0 while reset is high. in_ready = 1 in the first cycle after reset deasserts.
- Arithmetic: unsigned wrap-around for the sum. No saturation.
- Flags are a pure function of the stored S2 data for the bundle being presented.

Test Plan:
- WIDTH=16, out_ready=1, x=5, y=3, f=1, other controls 0 → out_valid one cycle after acceptance (second edge), out=8, zr=0, ng=0, cr=0, ov=0.
- x=5, y=3, nx=1, f=1, no=1 (x-y) → out=2, cr=0, ov=0. Then zx=1, nx=1, zy=1, f=1, no=0 (constant -1) → out=0xFFFF, ng=1, zr=0.
- Wrap and overflow flags:
  - x=0x7FFF, y=1, f=1 → out=0x8000, ng=1, ov=1, cr=0.
  - x=0xFFFF, y=1, f=1 → out=0, zr=1, cr=1, ov=0.
- Backpressure: out_ready=0, three back-to-back bundles (x=1, 2, 3; y=0; f=1).
  - in_ready drops after the 2nd is accepted.
  - out=1 is held stable.
  - Raising out_ready yields 1, 2, 3 in order, one per cycle.
  - The third bundle is accepted on the first edge with out_ready=1.
- Reset mid-flight: two bundles in flight, assert reset for 1 cycle → out_valid=0 and all outputs 0 after that edge. in_ready=0 during reset, 1 after. Neither old bundle ever appears.
- WIDTH=8 instance: x=0x80, y=0x80, f=1 → out=0, zr=1, cr=1, ov=1. Then x=0xF0, y=0x3C, f=0, no=1 → out=0xCF, ng=1, cr=0, ov=0.
